// File: rtl/key_event_queue_pkg.sv
// Shared constants and types for the keypad event queue: key code map,
// debounce FSM state encoding and the "keyed sample" predicate.
package key_pkg;

   localparam logic [3:0] KEY_NONE = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_ZERO = 4'd11;
   localparam logic [3:0] KEY_HASH = 4'd12;
   localparam logic [3:0] KEY_MIN  = 4'd1;
   localparam logic [3:0] KEY_MAX  = 4'd12;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } key_state_t;

   // A sample counts as a real key only when a column is high and the code
   // lies in the printable range; 0 and 13..15 mean "nothing usable".
   function automatic logic is_keyed(input logic p, input logic [3:0] k);
      return p && (k >= KEY_MIN) && (k <= KEY_MAX);
   endfunction

endpackage

// File: rtl/key_event_queue_fifo.sv
// Small first-word-fall-through FIFO for 4-bit key events. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [3:0]                 wdata,
   output logic                       full,
   input  logic                       pop,
   output logic                       valid,
   output logic [3:0]                 rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [3:0]    mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   cnt_r;
   logic          do_pop_s;
   logic          do_push_s;

   assign valid     = (cnt_r != {(AW+1){1'b0}});
   assign full      = (cnt_r == CNT_MAX);
   assign count     = cnt_r;
   assign do_pop_s  = pop && valid;
   assign do_push_s = push && (!full || do_pop_s);
   // Head is shown only while an entry exists so an empty FIFO reads 0.
   assign rdata     = valid ? mem_r[rptr_r] : 4'd0;

   // Storage write on accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= 4'd0;
      end else if (do_push_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r <= {AW{1'b0}};
         rptr_r <= {AW{1'b0}};
         cnt_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wptr_r <= wptr_r + PTR_ONE;
         if (do_pop_s)  rptr_r <= rptr_r + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_ONE;
            2'b01:   cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/key_event_queue.sv
// Keypad event queue: synchronises the raw scanner outputs, debounces press
// and release, emits one event per keystroke into a FIFO and flags drops.
module key_event_queue
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          press,
   input  logic [3:0]                    key_in,
   output logic                          out_valid,
   output logic [3:0]                    out_key,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          key_held,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          press_meta_r;
   logic          s_press;
   logic [3:0]    key_meta_r;
   logic [3:0]    s_key;
   key_state_t    state_r;
   key_state_t    state_nxt;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt;
   logic [3:0]    cand_r;
   logic [3:0]    cand_nxt;
   logic          push_s;
   logic          full_s;
   logic          keyed_s;
   logic          drop_s;
   logic          overflow_r;

   assign keyed_s  = is_keyed(s_press, s_key);
   assign key_held = (state_r == HELD) || (state_r == DEB_REL);
   // A push is dropped only when full and the consumer is not freeing a slot.
   assign drop_s   = push_s && full_s && !(out_valid && out_ready);
   assign overflow = overflow_r;

   // Two-flop synchroniser for the asynchronous scanner outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_meta_r <= 1'b0;
         s_press      <= 1'b0;
         key_meta_r   <= 4'd0;
         s_key        <= 4'd0;
      end else begin
         press_meta_r <= press;
         s_press      <= press_meta_r;
         key_meta_r   <= key_in;
         s_key        <= key_meta_r;
      end
   end

   // Debounce FSM state, counter and candidate registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         cand_r  <= 4'd0;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         cand_r  <= cand_nxt;
      end
   end

   // Debounce next-state logic; the event push happens on press acceptance.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      cand_nxt  = cand_r;
      push_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (keyed_s) begin
               cand_nxt  = s_key;
               cnt_nxt   = {CW{1'b0}};
               state_nxt = DEB_PRESS;
            end else begin
               state_nxt = IDLE;
            end
         end
         DEB_PRESS: begin
            if (!keyed_s || (s_key != cand_r)) begin
               state_nxt = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               push_s    = 1'b1;
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt_r + CNT_ONE;
            end
         end
         HELD: begin
            // Code changes while still pressed are ignored on purpose.
            if (!s_press) begin
               cnt_nxt   = {CW{1'b0}};
               state_nxt = DEB_REL;
            end else begin
               state_nxt = HELD;
            end
         end
         DEB_REL: begin
            if (s_press) begin
               state_nxt = HELD;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = {CW{1'b0}};
         end
      endcase
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_overflow) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (cand_r),
      .full  (full_s),
      .pop   (out_ready),
      .valid (out_valid),
      .rdata (out_key),
      .count (fifo_count)
   );

endmodule
